// File: rtl/uart_cmd_framer.sv
// Assembles UART receiver bytes into checksum-validated command frames
// (command byte, optional payload, XOR checksum) and presents them on a valid/ready handshake.
module uart_cmd_framer #(
   parameter int          PAYLOAD_BYTES = 44,
   parameter logic [7:0]  WORK_CMD      = 8'h01,
   parameter logic [7:0]  PING_CMD      = 8'h02
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 rx_byte,
   input  logic                       rx_data_ready,
   input  logic                       rx_error,
   input  logic                       rx_busy,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [7:0]                 cmd_code,
   output logic [PAYLOAD_BYTES*8-1:0] cmd_payload,
   output logic                       frame_error,
   output logic                       overflow,
   output logic                       busy
);

   localparam int PW = PAYLOAD_BYTES * 8;
   localparam int CW = $clog2(PAYLOAD_BYTES + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [7:0]    acc;
   logic [PW+7:0] payload_shift;
   logic          abort;

   // Shifting through a wider vector keeps this legal even for a single payload byte.
   assign payload_shift = {cmd_payload, rx_byte};
   assign abort         = rx_error || !rx_busy;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cmd_valid   <= 1'b0;
         cmd_code    <= 8'h00;
         cmd_payload <= '0;
         frame_error <= 1'b0;
         overflow    <= 1'b0;
         count       <= '0;
         acc         <= 8'h00;
      end else begin
         frame_error <= 1'b0;
         overflow    <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_data_ready) begin
                  if (rx_byte == WORK_CMD) begin
                     cmd_code <= rx_byte;
                     acc      <= rx_byte;
                     count    <= '0;
                     state    <= PAYLOAD;
                  end else if (rx_byte == PING_CMD) begin
                     cmd_code <= rx_byte;
                     acc      <= rx_byte;
                     state    <= CHECK;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (abort) begin
                  frame_error <= 1'b1;
                  state       <= IDLE;
               end else if (rx_data_ready) begin
                  cmd_payload <= payload_shift[PW-1:0];
                  acc         <= acc ^ rx_byte;
                  count       <= count + 1'b1;
                  if (count == LAST_IDX)
                     state <= CHECK;
               end
            end
            CHECK: begin
               if (abort) begin
                  frame_error <= 1'b1;
                  state       <= IDLE;
               end else if (rx_data_ready) begin
                  if (rx_byte == acc) begin
                     cmd_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            HOLD: begin
               // Any byte arriving while a frame is pending is lost, even on the release cycle.
               if (rx_data_ready)
                  overflow <= 1'b1;
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: directed scenarios plus randomized byte streams,
// checked every cycle against a queue-based frame model.
module tb_uart_cmd_framer;

   localparam int         N    = 44;
   localparam int         PW   = N * 8;
   localparam logic [7:0] WORK = 8'h01;
   localparam logic [7:0] PING = 8'h02;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          rx_data_ready = 1'b0;
   logic          rx_error = 1'b0;
   logic          rx_busy = 1'b1;
   logic          cmd_ready = 1'b0;
   logic          cmd_valid;
   logic [7:0]    cmd_code;
   logic [PW-1:0] cmd_payload;
   logic          frame_error;
   logic          overflow;
   logic          busy;

   int tests_run = 0;
   int tests_failed = 0;

   uart_cmd_framer #(.PAYLOAD_BYTES(N), .WORK_CMD(WORK), .PING_CMD(PING)) dut (
      .clk(clk),
      .reset(reset),
      .rx_byte(rx_byte),
      .rx_data_ready(rx_data_ready),
      .rx_error(rx_error),
      .rx_busy(rx_busy),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_code(cmd_code),
      .cmd_payload(cmd_payload),
      .frame_error(frame_error),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference model: collects the bytes of the frame in progress and judges it once complete.
   logic [7:0]    frame[$];
   logic          m_pending;
   logic [7:0]    m_code;
   logic [PW-1:0] m_payload;
   logic          m_ferr;
   logic          m_ovf;
   logic [7:0]    m_x;
   int            m_len;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         frame.delete();
         m_pending = 1'b0;
         m_code    = 8'h00;
         m_payload = '0;
         m_ferr    = 1'b0;
         m_ovf     = 1'b0;
      end else begin
         m_ferr = 1'b0;
         m_ovf  = 1'b0;
         if (m_pending) begin
            if (rx_data_ready) m_ovf = 1'b1;
            if (cmd_ready) m_pending = 1'b0;
         end else if (frame.size() != 0 && (rx_error || !rx_busy)) begin
            m_ferr = 1'b1;
            frame.delete();
         end else if (rx_data_ready) begin
            frame.push_back(rx_byte);
            if (frame[0] != WORK && frame[0] != PING) begin
               m_ferr = 1'b1;
               frame.delete();
            end else begin
               m_len = (frame[0] == WORK) ? N + 2 : 2;
               if (frame.size() == m_len) begin
                  m_x = 8'h00;
                  foreach (frame[i]) m_x = m_x ^ frame[i];
                  if (m_x == 8'h00) begin
                     m_pending = 1'b1;
                     m_code    = frame[0];
                     if (frame[0] == WORK)
                        for (int i = 0; i < N; i++) m_payload[PW-1-8*i -: 8] = frame[i+1];
                  end else begin
                     m_ferr = 1'b1;
                  end
                  frame.delete();
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("cmd_valid", PW'(cmd_valid), PW'(m_pending));
         checkOutput("busy", PW'(busy), PW'(m_pending || frame.size() != 0));
         checkOutput("frame_error", PW'(frame_error), PW'(m_ferr));
         checkOutput("overflow", PW'(overflow), PW'(m_ovf));
         if (m_pending) begin
            checkOutput("cmd_code", PW'(cmd_code), PW'(m_code));
            if (m_code == WORK) checkOutput("cmd_payload", cmd_payload, m_payload);
         end
      end
   end

   task automatic applyStimulus(input logic d, input logic [7:0] b, input logic e, input logic bz, input logic r);
      rx_data_ready = d;
      rx_byte       = b;
      rx_error      = e;
      rx_busy       = bz;
      cmd_ready     = r;
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic r);
      applyStimulus(1'b1, b, 1'b0, 1'b1, r);
   endtask

   task automatic idleCycle(input logic r);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, r);
   endtask

   task automatic sendWork(input logic [7:0] base);
      logic [7:0] chk;
      chk = WORK;
      sendByte(WORK, 1'b0);
      for (int i = 0; i < N; i++) begin
         sendByte(base + 8'(i), 1'b0);
         chk = chk ^ (base + 8'(i));
      end
      sendByte(chk, 1'b0);
   endtask

   task automatic doReset();
      rx_data_ready = 1'b0;
      rx_error      = 1'b0;
      rx_busy       = 1'b1;
      cmd_ready     = 1'b0;
      reset         = 1'b1;
      #2;
      checkOutput("reset cmd_valid", PW'(cmd_valid), '0);
      checkOutput("reset cmd_code", PW'(cmd_code), '0);
      checkOutput("reset cmd_payload", cmd_payload, '0);
      checkOutput("reset frame_error", PW'(frame_error), '0);
      checkOutput("reset overflow", PW'(overflow), '0);
      checkOutput("reset busy", PW'(busy), '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic randCycle(input logic d, input logic [7:0] b);
      logic r;
      r = ($urandom_range(0, 2) == 0);
      if (d)
         applyStimulus(1'b1, b, ($urandom_range(0, 100) == 0), 1'b1, r);
      else
         applyStimulus(1'b0, 8'($urandom), ($urandom_range(0, 60) == 0), ($urandom_range(0, 30) != 0), r);
   endtask

   task automatic sendRandomFrame();
      logic [7:0] q[$];
      logic [7:0] chk;
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
         0: q = '{PING};
         1, 2, 3: begin
            q = '{WORK};
            for (int i = 0; i < N; i++) q.push_back(8'($urandom));
         end
         4: q = '{8'($urandom)};
         default: begin
            q = '{WORK};
            for (int i = 0; i < int'($urandom_range(1, N - 1)); i++) q.push_back(8'($urandom));
         end
      endcase
      if (kind <= 3) begin
         chk = 8'h00;
         foreach (q[i]) chk = chk ^ q[i];
         if (kind == 3) chk = chk ^ 8'(($urandom_range(1, 255)));
         q.push_back(chk);
      end
      foreach (q[i]) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) randCycle(1'b0, 8'h00);
         randCycle(1'b1, q[i]);
      end
      if (kind == 5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1;
      doReset();

      sendByte(8'h7F, 1'b0);
      checkOutput("unknown code frame_error", PW'(frame_error), PW'(1'b1));
      checkOutput("unknown code busy", PW'(busy), '0);
      idleCycle(1'b0);
      checkOutput("unknown code pulse ends", PW'(frame_error), '0);

      sendByte(PING, 1'b0);
      sendByte(PING, 1'b0);
      checkOutput("ping cmd_valid", PW'(cmd_valid), PW'(1'b1));
      checkOutput("ping cmd_code", PW'(cmd_code), PW'(8'h02));
      idleCycle(1'b1);
      checkOutput("ping release valid", PW'(cmd_valid), '0);
      checkOutput("ping release busy", PW'(busy), '0);

      sendWork(8'h00);
      checkOutput("work cmd_valid", PW'(cmd_valid), PW'(1'b1));
      checkOutput("work top byte", PW'(cmd_payload[PW-1 -: 8]), PW'(8'h00));
      checkOutput("work bottom byte", PW'(cmd_payload[7:0]), PW'(8'h2B));
      checkOutput("work no frame_error", PW'(frame_error), '0);
      idleCycle(1'b1);

      sendByte(PING, 1'b0);
      sendByte(8'h03, 1'b0);
      checkOutput("bad checksum frame_error", PW'(frame_error), PW'(1'b1));
      checkOutput("bad checksum cmd_valid", PW'(cmd_valid), '0);
      checkOutput("bad checksum busy", PW'(busy), '0);
      sendByte(PING, 1'b0);
      sendByte(PING, 1'b0);
      checkOutput("ping after bad valid", PW'(cmd_valid), PW'(1'b1));
      idleCycle(1'b1);

      sendByte(WORK, 1'b0);
      for (int i = 0; i < 10; i++) sendByte(8'(i), 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("gap frame_error", PW'(frame_error), PW'(1'b1));
      checkOutput("gap busy", PW'(busy), '0);
      sendWork(8'h40);
      checkOutput("work after gap valid", PW'(cmd_valid), PW'(1'b1));
      checkOutput("work after gap top", PW'(cmd_payload[PW-1 -: 8]), PW'(8'h40));
      checkOutput("work after gap bottom", PW'(cmd_payload[7:0]), PW'(8'h6B));
      idleCycle(1'b1);

      sendByte(PING, 1'b0);
      sendByte(PING, 1'b0);
      sendByte(8'h55, 1'b0);
      checkOutput("overflow pulse", PW'(overflow), PW'(1'b1));
      checkOutput("overflow cmd_code", PW'(cmd_code), PW'(8'h02));
      checkOutput("overflow cmd_valid", PW'(cmd_valid), PW'(1'b1));
      idleCycle(1'b1);
      checkOutput("overflow release valid", PW'(cmd_valid), '0);
      checkOutput("overflow pulse ends", PW'(overflow), '0);

      sendByte(WORK, 1'b0);
      for (int i = 0; i < 20; i++) sendByte(8'(i), 1'b0);
      doReset();
      sendByte(PING, 1'b0);
      sendByte(PING, 1'b0);
      checkOutput("ping after reset valid", PW'(cmd_valid), PW'(1'b1));
      checkOutput("ping after reset code", PW'(cmd_code), PW'(8'h02));
      idleCycle(1'b1);

      for (int f = 0; f < 60; f++) sendRandomFrame();
      for (int k = 0; k < 4; k++) idleCycle(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
